// File: rtl/oled_rect_fill_if.sv
// Pixel request port between the rectangle fill engine and the SSD1331 SPI driver.
// The engine drives through the master modport; the driver answers through the slave modport.
interface oled_rect_fill_if;
  logic        pix_setpixel;
  logic [7:0]  pix_x;
  logic [7:0]  pix_y;
  logic [15:0] pix_rgb;
  logic        pix_valid;
  logic        pix_ready;

  modport master (
    output pix_setpixel,
    output pix_x,
    output pix_y,
    output pix_rgb,
    output pix_valid,
    input  pix_ready
  );

  modport slave (
    input  pix_setpixel,
    input  pix_x,
    input  pix_y,
    input  pix_rgb,
    input  pix_valid,
    output pix_ready
  );
endinterface

// File: rtl/oled_rect_fill.sv
// Rectangle fill engine: walks each covered pixel in raster order and issues one set-pixel request per pixel.
// Optional panel clipping is enabled with the macro OLED_RECT_CLIP_EN.
module oled_rect_fill #(
  parameter int WIDTH  = 96,
  parameter int HEIGHT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_x0,
  input  logic [7:0]  cmd_y0,
  input  logic [7:0]  cmd_x1,
  input  logic [7:0]  cmd_y1,
  input  logic [15:0] cmd_rgb,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [12:0] pix_count,
  oled_rect_fill_if.master pix
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_ADVANCE = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_s;

  logic [7:0]  x0_r, y0_r, x1_r, y1_r;
  logic [15:0] rgb_r;
  logic [7:0]  xl_r, xh_r, yl_r, yh_r;
  logic [7:0]  cur_x_r, cur_y_r;
  logic        abort_seen_r;
  logic        busy_r;
  logic        done_r;
  logic [12:0] pix_count_r;
  logic [7:0]  pix_x_r, pix_y_r;
  logic [15:0] pix_rgb_r;
  logic        pix_valid_r;

  logic [7:0]  xl_s, xh_s, yl_s, yh_s;
  logic [7:0]  xh_raw_s, yh_raw_s;
  logic        empty_s;
  logic        stop_s;

`ifdef OLED_RECT_CLIP_EN
  localparam logic [7:0] X_MAX = 8'(WIDTH - 1);
  localparam logic [7:0] Y_MAX = 8'(HEIGHT - 1);
`endif

  // Normalise the latched corners and apply optional clipping.
  always_comb begin
    xl_s     = x0_r;
    xh_raw_s = x1_r;
    yl_s     = y0_r;
    yh_raw_s = y1_r;
    if (x0_r > x1_r) begin
      xl_s     = x1_r;
      xh_raw_s = x0_r;
    end else begin
      xl_s     = x0_r;
      xh_raw_s = x1_r;
    end
    if (y0_r > y1_r) begin
      yl_s     = y1_r;
      yh_raw_s = y0_r;
    end else begin
      yl_s     = y0_r;
      yh_raw_s = y1_r;
    end
`ifdef OLED_RECT_CLIP_EN
    xh_s    = (xh_raw_s > X_MAX) ? X_MAX : xh_raw_s;
    yh_s    = (yh_raw_s > Y_MAX) ? Y_MAX : yh_raw_s;
    empty_s = (xl_s > X_MAX) || (yl_s > Y_MAX);
`else
    xh_s    = xh_raw_s;
    yh_s    = yh_raw_s;
    empty_s = 1'b0;
`endif
  end

  // An abort arriving in the ADVANCE cycle itself still stops the walk.
  assign stop_s = abort_seen_r | abort | ((cur_x_r == xh_r) && (cur_y_r == yh_r));

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (cmd_valid) state_s = S_SETUP;
        else           state_s = S_IDLE;
      end
      S_SETUP: begin
        if (empty_s) state_s = S_FINISH;
        else         state_s = S_ISSUE;
      end
      S_ISSUE:  state_s = S_WAIT;
      S_WAIT: begin
        if (pix.pix_ready) state_s = S_ADVANCE;
        else               state_s = S_WAIT;
      end
      S_ADVANCE: begin
        if (stop_s) state_s = S_FINISH;
        else        state_s = S_ISSUE;
      end
      S_FINISH: state_s = S_IDLE;
      default:  state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= S_IDLE;
    else       state_r <= state_s;
  end

  // Command latch, pixel walk, request outputs and status.
  always_ff @(posedge clk) begin
    if (reset) begin
      x0_r         <= 8'd0;
      y0_r         <= 8'd0;
      x1_r         <= 8'd0;
      y1_r         <= 8'd0;
      rgb_r        <= 16'd0;
      xl_r         <= 8'd0;
      xh_r         <= 8'd0;
      yl_r         <= 8'd0;
      yh_r         <= 8'd0;
      cur_x_r      <= 8'd0;
      cur_y_r      <= 8'd0;
      abort_seen_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pix_count_r  <= 13'd0;
      pix_x_r      <= 8'd0;
      pix_y_r      <= 8'd0;
      pix_rgb_r    <= 16'd0;
      pix_valid_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state_r == S_IDLE) begin
        abort_seen_r <= 1'b0;
      end else if (abort) begin
        abort_seen_r <= 1'b1;
      end
      case (state_r)
        S_IDLE: begin
          if (cmd_valid) begin
            x0_r        <= cmd_x0;
            y0_r        <= cmd_y0;
            x1_r        <= cmd_x1;
            y1_r        <= cmd_y1;
            rgb_r       <= cmd_rgb;
            pix_count_r <= 13'd0;
            busy_r      <= 1'b1;
          end
        end
        S_SETUP: begin
          xl_r    <= xl_s;
          xh_r    <= xh_s;
          yl_r    <= yl_s;
          yh_r    <= yh_s;
          cur_x_r <= xl_s;
          cur_y_r <= yl_s;
          if (empty_s) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            // First pixel goes out straight from setup so it is visible in ISSUE.
            pix_x_r     <= xl_s;
            pix_y_r     <= yl_s;
            pix_rgb_r   <= rgb_r;
            pix_valid_r <= 1'b1;
          end
        end
        S_ISSUE: begin
          pix_x_r     <= cur_x_r;
          pix_y_r     <= cur_y_r;
          pix_rgb_r   <= rgb_r;
          pix_valid_r <= 1'b1;
        end
        S_WAIT: begin
          if (pix.pix_ready) begin
            pix_valid_r <= 1'b0;
            if (pix_count_r != 13'h1FFF) pix_count_r <= pix_count_r + 13'd1;
          end
        end
        S_ADVANCE: begin
          if (stop_s) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else if (cur_x_r == xh_r) begin
            cur_x_r <= xl_r;
            cur_y_r <= cur_y_r + 8'd1;
          end else begin
            cur_x_r <= cur_x_r + 8'd1;
          end
        end
        S_FINISH: begin
          busy_r <= 1'b0;
        end
        default: begin
          busy_r      <= 1'b0;
          pix_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready        = (state_r == S_IDLE) && cmd_valid;
  assign busy             = busy_r;
  assign done             = done_r;
  assign pix_count        = pix_count_r;
  assign pix.pix_setpixel = 1'b1;
  assign pix.pix_x        = pix_x_r;
  assign pix.pix_y        = pix_y_r;
  assign pix.pix_rgb      = pix_rgb_r;
  assign pix.pix_valid    = pix_valid_r;

endmodule

// File: doc/oled_rect_fill.md
# oled_rect_fill

Rectangle fill engine that sits directly upstream of the SSD1331 OLED SPI driver. It accepts one rectangle command (two corners plus an RGB565 colour) from the CPU bus side. It walks every covered pixel in raster order and issues one set-pixel request per pixel on the driver's valid/ready pixel port. This offloads per-pixel bus traffic from the rv32im core.

## Interface
Parameters:
- WIDTH, 96, panel columns; valid x is 0..WIDTH-1
- HEIGHT, 64, panel rows; valid y is 0..HEIGHT-1

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset (single clock domain)
- cmd_valid  in  1  rectangle command present
- cmd_ready  out  1  one-cycle accept pulse
- cmd_x0, cmd_y0, cmd_x1, cmd_y1  in  8 each  corner coordinates (inclusive, any order)
- cmd_rgb  in  16  RGB565 fill colour
- abort  in  1  stop after the in-flight pixel
- busy  out  1  high from accept until done
- done  out  1  one-cycle completion pulse
- pix_count  out  13  pixels issued for current/last command
- pix_setpixel  out  1  constant 1 (selects driver pixel mode)
- pix_x  out  8  pixel column to driver
- pix_y  out  8  pixel row to driver
- pix_rgb  out  16  pixel colour to driver
- pix_valid  out  1  pixel request to driver
- pix_ready  in  1  driver completion pulse (one cycle)

## Operation
- States: IDLE, SETUP, ISSUE, WAIT, ADVANCE, FINISH.
- IDLE: cmd_ready = cmd_valid. On cmd_valid, latch the corners and colour, clear pix_count, set busy, and go to SETUP.
- SETUP normalises the rectangle: xl = min(x0,x1), xh = max(x0,x1); yl and yh likewise. It then applies clipping (see Configuration).
  - Empty rectangle after clipping: go to FINISH.
  - Otherwise: cur_x = xl, cur_y = yl, go to ISSUE.
- ISSUE: drive pix_x = cur_x, pix_y = cur_y, pix_rgb = colour; assert pix_valid; go to WAIT.
- WAIT: hold pix_valid and all pix_* stable until pix_ready is sampled high. Then deassert pix_valid on the next edge, increment pix_count, and go to ADVANCE. pix_ready seen outside WAIT is ignored.
- ADVANCE picks the next step in this priority order:
  - abort was seen since the last ISSUE: go to FINISH.
  - cur_x == xh and cur_y == yh: go to FINISH.
  - cur_x == xh: cur_x = xl, cur_y + 1, go to ISSUE.
  - Otherwise: cur_x + 1, go to ISSUE.
- FINISH: pulse done for one cycle, clear busy, return to IDLE.
- Arithmetic: coordinates are 8-bit unsigned. Increments never wrap because the loop ends at xh/yh. pix_count saturates at 8191.
- A new cmd_valid while busy is ignored (cmd_ready stays 0).
- abort in IDLE has no effect. abort is sticky within a command; it is cleared on accept.
- Simultaneous abort and the last pixel's pix_ready: a single done pulse, identical to a normal finish.

## Timing
- Reset values: cmd_ready=0, busy=0, done=0, pix_valid=0, pix_x=0, pix_y=0, pix_rgb=0, pix_count=0, pix_setpixel=1. State goes to IDLE.
- Reset mid-operation abandons the rectangle immediately; no done pulse is generated.
- Latency from accept to the first pix_valid:
  - Accept at edge N (cmd_ready high in cycle N).
  - SETUP in cycle N+1.
  - pix_valid high from cycle N+2.
- Gap between pixels: pix_ready at cycle M, then pix_valid low in cycles M+1 and M+2, then high again in M+3. The driver therefore never sees valid & !ready on its ready pulse, and valid is low for at least one full cycle.
- done is high in the cycle after the final ADVANCE. busy falls in the same cycle that done rises.
- Empty rectangle: done at cycle N+2, with zero pixels issued.

## Configuration
- Macro: OLED_RECT_CLIP_EN.
- Defined:
  - xh = min(xh, WIDTH-1) and yh = min(yh, HEIGHT-1).
  - If xl >= WIDTH or yl >= HEIGHT, the rectangle is empty: done with no pixels issued.
- Undefined:
  - No clipping; coordinates are passed to the driver unmodified.
  - The only empty case is none: every command issues at least one pixel.

## Test plan
- Corners (2,3)-(4,4), rgb=16'hF800 -> six requests in the order (2,3),(3,3),(4,3),(2,4),(3,4),(4,4), all rgb F800; pix_count=6; one done pulse.
- Swapped corners (4,4)-(2,3) -> identical sequence and count as above.
- With OLED_RECT_CLIP_EN, corners (94,62)-(120,200) -> four pixels (94,62),(95,62),(94,63),(95,63). Corners (100,0)-(110,5) -> done at N+2 with pix_count=0 and pix_valid never high.
- Driver model with ready delayed 40 cycles, and abort asserted during pixel 2 of a 10x1 rectangle -> pix_* held stable while waiting; exactly 2 pixels issued; done pulses once; pix_count=2.
- cmd_valid re-asserted while busy -> cmd_ready stays 0 and the rectangle completes unchanged. Reset asserted mid-fill -> all outputs take their reset values on the next edge, with no done pulse.
